// File: rtl/button_reader.sv
// Board push-button front end: two-flop synchroniser, tick-based per-bit
// debounce, registered press/release pulses and a wrapping press counter.
module button_reader #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned TICK_PERIOD  = 1024,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] BTN,
  output logic [WIDTH-1:0] BTN_STATE,
  output logic [WIDTH-1:0] BTN_PRESS,
  output logic [WIDTH-1:0] BTN_RELEASE,
  output logic [7:0]       PRESS_COUNT
);

  localparam int unsigned TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int unsigned STAB_W = 8;

  logic [WIDTH-1:0]  sync1_q, sync1_d;
  logic [WIDTH-1:0]  sync2_q, sync2_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [STAB_W-1:0] stable_q [WIDTH];
  logic [STAB_W-1:0] stable_d [WIDTH];
  logic [WIDTH-1:0]  state_q, state_d;
  logic [WIDTH-1:0]  press_q, press_d;
  logic [WIDTH-1:0]  release_q, release_d;
  logic [7:0]        count_q, count_d;
  logic              tick_c;

  always_comb begin
    sync1_d    = BTN;
    sync2_d    = sync1_q;
    tick_c     = (tick_cnt_q == TICK_W'(TICK_PERIOD - 1));
    tick_cnt_d = tick_c ? '0 : TICK_W'(tick_cnt_q + TICK_W'(1));
    state_d    = state_q;
    stable_d   = stable_q;
    press_d    = '0;
    release_d  = '0;

    // Debounce only advances on the shared slow tick; a bounce back resets progress.
    if (tick_c) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2_q[i] == state_q[i]) begin
          stable_d[i] = '0;
        end else if (STAB_W'(stable_q[i] + STAB_W'(1)) == STAB_W'(STABLE_TICKS)) begin
          state_d[i]   = sync2_q[i];
          stable_d[i]  = '0;
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          stable_d[i] = STAB_W'(stable_q[i] + STAB_W'(1));
        end
      end
    end

    count_d = 8'(count_q + {7'd0, |press_d});
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      stable_q   <= '{default: '0};
      state_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      count_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      count_q    <= count_d;
    end
  end

  assign BTN_STATE   = state_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;
  assign PRESS_COUNT = count_q;

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the board LED driver: samples raw push-buttons/switches and synchronises them into the CLK domain.
- Debounces each bit using a shared slow sample tick.
- Reports the debounced state, one-cycle press/release pulses and a free-running press counter.
- Sits between the board input pins and user logic (e.g. a pattern selector feeding the LED block).

Parameters:
- WIDTH, 8, number of button/switch inputs.
- TICK_PERIOD, 1024, CLK cycles per debounce sample tick; legal range ≥2.
- STABLE_TICKS, 4, consecutive ticks a synchronised bit must differ from the debounced state before the state flips; legal range ≥1, ≤255.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-low reset (asserted when 0, sampled on rising CLK).
- BTN  input  WIDTH  raw asynchronous button levels, 1 = pressed.
- BTN_STATE  output  WIDTH  debounced level per bit.
- BTN_PRESS  output  WIDTH  one-cycle pulse per bit on debounced 0→1.
- BTN_RELEASE  output  WIDTH  one-cycle pulse per bit on debounced 1→0.
- PRESS_COUNT  output  8  count of cycles in which any BTN_PRESS bit was set; wraps.

Behaviour:
- Reset (RST=0 at a rising edge) clears all of the following:
  - both synchroniser stages
  - tick counter
  - every per-bit stable counter
  - BTN_STATE, BTN_PRESS, BTN_RELEASE and PRESS_COUNT, all to 0
- Reset overrides everything in that cycle, including mid-debounce.
- After reset release, no press is reported for a button already held until the full debounce qualifies it.
- Synchroniser: two flops per bit, sync1<=BTN, sync2<=sync1. A BTN change before edge n appears in sync2 after edge n+1.
- Tick counter:
  - Counts 0..TICK_PERIOD-1 and wraps to 0.
  - Tick is asserted combinationally while the counter equals TICK_PERIOD-1.
  - The first tick after reset is in cycle TICK_PERIOD-1.
- Per-bit debounce, evaluated only in tick cycles:
  - If sync2[i]==BTN_STATE[i]: stable counter[i]<=0.
  - Else if stable counter[i]+1==STABLE_TICKS: BTN_STATE[i]<=sync2[i] and stable counter[i]<=0.
  - Else: stable counter[i]<=stable counter[i]+1.
  - In non-tick cycles, state and counters hold.
- A bounce back to the old level on any tick discards accumulated progress (counter to 0).
- Edge pulses:
  - BTN_PRESS[i] and BTN_RELEASE[i] are registered at the same edge that updates BTN_STATE[i].
  - They are high for exactly the first cycle BTN_STATE[i] shows its new value and 0 otherwise.
  - They are never both high for one bit.
- PRESS_COUNT increments by 1 (mod 256) at the edge where any BTN_PRESS bit becomes 1. Simultaneous presses of several bits count once.
- Latency: from a clean BTN transition to the BTN_STATE change is at least (STABLE_TICKS-1)*TICK_PERIOD+1 and at most 2+STABLE_TICKS*TICK_PERIOD cycles.
- Glitch rejection: any pulse shorter than (STABLE_TICKS-1)*TICK_PERIOD cycles never changes BTN_STATE.
- Bits are fully independent except for the shared tick and PRESS_COUNT.

Test Plan (WIDTH=8, TICK_PERIOD=4, STABLE_TICKS=3 unless noted):
- Reset check:
  - Stimulus: hold RST=0 for 5 cycles with BTN=8'hFF.
  - Required: all outputs are 0 during reset.
  - Required: after release, BTN_STATE=8'hFF appears within 14 cycles and BTN_PRESS=8'hFF pulses exactly one cycle.
  - Required: PRESS_COUNT=1.
- Clean press/release:
  - Stimulus: BTN[0] 0→1, held for 40 cycles, then 1→0.
  - Required: BTN_STATE[0] rises within 9..14 cycles of the press with a single BTN_PRESS[0] pulse.
  - Required: BTN_STATE[0] falls within 9..14 cycles of the release with a single BTN_RELEASE[0] pulse.
  - Required: PRESS_COUNT goes 0→1.
- Bounce rejection:
  - Stimulus: toggle BTN[3] with a 6-cycle high / 6-cycle low pattern for 60 cycles.
  - Required: BTN_STATE[3] stays 0, no pulses, PRESS_COUNT unchanged.
- Simultaneous presses:
  - Stimulus: BTN 8'h00→8'h81 at the same cycle.
  - Required: BTN_PRESS=8'h81 for one cycle.
  - Required: PRESS_COUNT increments by exactly 1.
- Counter wrap:
  - Stimulus: 256 qualified press/release cycles of BTN[1].
  - Required: PRESS_COUNT reads 255 after press 255 and 0 after press 256.
- Mid-operation reset:
  - Stimulus: press BTN[2]; assert RST=0 for 1 cycle after 2 ticks of qualification; keep BTN[2]=1.
  - Required: BTN_STATE[2] is 0 after reset.
  - Required: re-qualification takes the full 9..14 cycles from reset release.
  - Required: exactly one BTN_PRESS[2] pulse, PRESS_COUNT=1.
